// File: rtl/dfp_arbiter.sv
// Round-robin arbiter/sequencer sharing one dfp unit between NUM_REQ requesters.
// Optional response watchdog is enabled by defining DFP_ARB_TIMEOUT_EN.
module dfp_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GW             = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2*NUM_REQ-1:0]  req_mode,
    input  logic [64*NUM_REQ-1:0] req_a,
    input  logic [64*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [63:0]           rsp_data,
    output logic                  rsp_err,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [1:0]            dfp_calc_mode,
    output logic [63:0]           dfp_a,
    output logic [63:0]           dfp_b,
    output logic                  dfp_wvalid,
    input  logic                  dfp_wready,
    input  logic [63:0]           dfp_o,
    input  logic                  dfp_rvalid,
    output logic                  dfp_rready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] grant;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] win_idx;
    logic          win_found;
    logic [GW:0]   cand;

`ifdef DFP_ARB_TIMEOUT_EN
    localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
    logic [CNT_W-1:0] wd_cnt;
`endif

    // Search starts at rr_ptr and wraps, so the last-served requester is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ))
                cand = cand - (GW+1)'(NUM_REQ);
            if (!win_found && req_valid[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && rstn && win_found)
            req_ready[win_idx] = 1'b1;
    end

    assign grant_nxt = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef DFP_ARB_TIMEOUT_EN
    // Results arriving outside WAIT are stale leftovers of a timed-out op; drain them.
    assign dfp_rready = rstn && (state != RESP);
`else
    assign dfp_rready = (state == WAIT);
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            rsp_data      <= '0;
            rsp_valid     <= '0;
            dfp_wvalid    <= 1'b0;
            dfp_calc_mode <= '0;
            dfp_a         <= '0;
            dfp_b         <= '0;
`ifdef DFP_ARB_TIMEOUT_EN
            rsp_err       <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant         <= win_idx;
                        dfp_calc_mode <= req_mode[{win_idx, 1'b0} +: 2];
                        dfp_a         <= req_a[{win_idx, 6'd0} +: 64];
                        dfp_b         <= req_b[{win_idx, 6'd0} +: 64];
                        dfp_wvalid    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dfp_wready) begin
                        dfp_wvalid <= 1'b0;
                        state      <= WAIT;
`ifdef DFP_ARB_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (dfp_rvalid) begin
                        rsp_data  <= dfp_o;
                        rsp_valid <= NUM_REQ'(1) << grant;
                        state     <= RESP;
`ifdef DFP_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data  <= QNAN;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << grant;
                        state     <= RESP;
                    end else begin
                        wd_cnt    <= wd_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= grant_nxt;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dfp_arbiter.md
# dfp_arbiter

Round-robin arbiter and sequencer that shares one `dfp` double-precision floating-point processor between `NUM_REQ` requesters. It accepts one operation at a time from the winning requester and drives the `dfp` write handshake with the registered operands. It then collects the `dfp` result and returns it only to the requester that issued it. It sits between the compute clients and the single `dfp` instance.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `GW`, `$clog2(NUM_REQ)`, grant index width; derived, not overridden.
- `TIMEOUT_CYCLES`, 1023, watchdog limit in cycles; used only when `DFP_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_mode` in 2*NUM_REQ: per-requester `calc_mode`; slice i is `[2i+1:2i]`.
- `req_a` in 64*NUM_REQ: per-requester operand A.
- `req_b` in 64*NUM_REQ: per-requester operand B.
- `req_valid` in NUM_REQ: request valid.
- `req_ready` out NUM_REQ: request accepted; at most one bit high.
- `rsp_data` out 64: result, shared by all requesters.
- `rsp_err` out 1: result is a timeout substitute.
- `rsp_valid` out NUM_REQ: response valid; at most one bit high.
- `rsp_ready` in NUM_REQ: response accepted.
- `dfp_calc_mode` out 2: drives `dfp` `calc_mode`.
- `dfp_a` out 64: drives `dfp` operand A.
- `dfp_b` out 64: drives `dfp` operand B.
- `dfp_wvalid` out 1: write handshake valid toward `dfp`.
- `dfp_wready` in 1: write handshake ready from `dfp`.
- `dfp_o` in 64: `dfp` result.
- `dfp_rvalid` in 1: result valid from `dfp`.
- `dfp_rready` out 1: result ready toward `dfp`.

## Operation
- At most one operation is outstanding at the `dfp`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping at `NUM_REQ-1` → 0.
  - `req_ready[winner]` is combinational and high only in IDLE.
  - On handshake: capture mode, A, B and winner into `grant`, then go to ISSUE.
- ISSUE: `dfp_wvalid`=1 with captured operands. On `dfp_wready`=1, go to WAIT.
- WAIT: `dfp_rready`=1. On `dfp_rvalid`=1, register `dfp_o` into `rsp_data`, clear `rsp_err`, then go to RESP.
- RESP:
  - `rsp_valid[grant]`=1; `rsp_data` is held stable.
  - On `rsp_ready[grant]`=1: set `rr_ptr`=(grant+1) mod `NUM_REQ`, then go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- A requester that keeps `req_valid` high after being served loses priority to every other active requester.
- `req_*` inputs are sampled only at the IDLE handshake. Later changes do not affect the operation in flight.
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, `rsp_data`=0, `rsp_err`=0, all `req_ready`/`rsp_valid`=0, `dfp_wvalid`=0, `dfp_rready`=0, `dfp_calc_mode`/`dfp_a`/`dfp_b`=0.
- Reset mid-operation: the in-flight op is abandoned with no response. `dfp` shares `rstn` and is cleared with the arbiter.

## Timing
- Minimum turnaround, with `dfp_wready`, `dfp_rvalid` and `rsp_ready` all high immediately:
  - cycle 0: accept;
  - cycle 1: issue;
  - cycle 2: result captured;
  - cycle 3: response handshake;
  - cycle 4: IDLE, next grant possible.
- Requester-observed latency = 3 + `dfp` compute latency cycles.
- Valid/ready rules, both sides:
  - valid never drops before its ready;
  - data is stable while valid is high;
  - ready may precede valid.

## Configuration
- Macro: `DFP_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT. If `TIMEOUT_CYCLES` cycles pass without `dfp_rvalid`, go to RESP with `rsp_data`=64'h7FF8_0000_0000_0000 (qNaN) and `rsp_err`=1.
  - `dfp_rready` is also high in IDLE and ISSUE. A result arriving outside WAIT is stale and is discarded.
  - If `dfp_rvalid` arrives in the same cycle the counter expires, the real result wins.
- Undefined:
  - No counter; WAIT is held indefinitely.
  - `rsp_err` is tied to 0.
  - `dfp_rready` is high only in WAIT.

## Test plan
- Single request: `req_valid[2]`, mode 2'b01, A=64'h3FF0_0000_0000_0000, B=64'h4000_0000_0000_0000. The `dfp` model returns 64'h4008_0000_0000_0000 with 0 delay → `rsp_valid[2]` at cycle 3 with that data, `rsp_err`=0.
- All four requesters valid continuously from reset → grant order 0,1,2,3,0. No requester is served twice before all others have been served.
- `dfp_wready` held low 5 cycles, then `dfp_rvalid` delayed 10 cycles → operands and `dfp_wvalid` are stable throughout, and exactly one response is delivered.
- `rsp_ready[1]` low 7 cycles while `req_valid[0]` is high → `rsp_valid[1]` and `rsp_data` are held; no new grant until the response handshake completes.
- With `DFP_ARB_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=16, `dfp` never responds → response at WAIT+16 with qNaN data and `rsp_err`=1. A late `dfp_rvalid` in IDLE is discarded, and the next op completes normally.
- `rstn` asserted in WAIT → all outputs return to reset values immediately, and the next request is granted from requester 0 first.
